// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared encodings for the register-file write-port arbiter and its scoreboard.
// Pure declarations: no logic, no latency.
package regfile_wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_WB   = 2'd1,
    GRANT_MC   = 2'd2
  } grant_e;

  typedef enum logic {
    WB_PRI = 1'b0,
    MC_PRI = 1'b1
  } pri_e;

endpackage

// File: rtl/regfile_wb_arbiter_reg_scoreboard.sv
// Busy scoreboard of registers awaiting a multi-cycle result; set on issue, cleared on MC commit.
// issue_ready and lookups are combinational from the registered vector; updates land on the next edge.
module reg_scoreboard
  import regfile_wb_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  output logic                  issue_ready,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_rd,
  input  logic [REG_ADDR_W-1:0] chk_rs1,
  input  logic [REG_ADDR_W-1:0] chk_rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy
);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;

  assign issue_ready = !reset && !busy[issue_rd];
  assign rs1_busy    = busy[chk_rs1];
  assign rs2_busy    = busy[chk_rs2];

  always_comb begin
    busy_nxt = busy;
    if (clr_en)
      busy_nxt[clr_rd] = 1'b0;
    if (issue_valid && issue_ready)
      busy_nxt[issue_rd] = 1'b1;
    // x0 never has a pending result
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset)
      busy <= '0;
    else
      busy <= busy_nxt;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between pipeline writeback and a multi-cycle unit with anti-starvation.
// Zero-latency combinational grant; losing requester sees ready low and must hold its request.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  output logic                  wb_ready,
  input  logic                  mc_valid,
  input  logic [REG_ADDR_W-1:0] mc_rd,
  input  logic [XLEN-1:0]       mc_data,
  output logic                  mc_ready,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  output logic                  issue_ready,
  input  logic [REG_ADDR_W-1:0] chk_rs1,
  input  logic [REG_ADDR_W-1:0] chk_rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_a3,
  output logic [XLEN-1:0]       rf_wd
);

  localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);
  localparam logic [3:0] WAIT_SAT  = 4'(MAX_WAIT);

  pri_e       pri;
  logic [3:0] wait_cnt;
  grant_e     grant;
  logic       mc_grant;

  always_comb begin
    grant = GRANT_NONE;
    if (!reset) begin
      if (pri == WB_PRI) begin
        if (wb_valid)      grant = GRANT_WB;
        else if (mc_valid) grant = GRANT_MC;
      end else begin
        if (mc_valid)      grant = GRANT_MC;
        else if (wb_valid) grant = GRANT_WB;
      end
    end
  end

  assign mc_grant = (grant == GRANT_MC);
  assign wb_ready = wb_valid && (grant == GRANT_WB);
  assign mc_ready = mc_valid && mc_grant;

  always_comb begin
    rf_we = 1'b0;
    rf_a3 = '0;
    rf_wd = '0;
    if (grant == GRANT_WB) begin
      rf_we = (wb_rd != '0);
      rf_a3 = wb_rd;
      rf_wd = wb_data;
    end else if (grant == GRANT_MC) begin
      rf_we = (mc_rd != '0);
      rf_a3 = mc_rd;
      rf_wd = mc_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pri      <= WB_PRI;
      wait_cnt <= '0;
    end else begin
      if (!mc_valid || mc_grant)
        wait_cnt <= '0;
      else if (wait_cnt != WAIT_SAT)
        wait_cnt <= wait_cnt + 4'd1;

      case (pri)
        WB_PRI: if (mc_valid && !mc_grant && wait_cnt == WAIT_LAST) pri <= MC_PRI;
        MC_PRI: if (mc_grant || !mc_valid) pri <= WB_PRI;
        default: pri <= WB_PRI;
      endcase
    end
  end

  reg_scoreboard u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .clr_en      (mc_ready),
    .clr_rd      (mc_rd),
    .chk_rs1     (chk_rs1),
    .chk_rs2     (chk_rs2),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench: stimulus predicts each cycle's outputs from a refusal-streak model, a negedge monitor compares.
module tb_regfile_wb_arbiter;

  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid, mc_valid, issue_valid;
  logic [4:0]  wb_rd, mc_rd, issue_rd, chk_rs1, chk_rs2;
  logic [31:0] wb_data, mc_data;
  logic        wb_ready, mc_ready, issue_ready, rs1_busy, rs2_busy, rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready),
    .mc_valid(mc_valid), .mc_rd(mc_rd), .mc_data(mc_data), .mc_ready(mc_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd)
  );

  typedef struct packed {
    logic        wb_ready;
    logic        mc_ready;
    logic        rf_we;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd;
    logic        issue_ready;
    logic        rs1_busy;
    logic        rs2_busy;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  // Model: MC wins once it has been refused MAX_WAIT cycles in a row.
  int          streak = 0;
  logic [31:0] mbusy = '0;
  logic        last_gw, last_gm;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("wb_ready",    32'(wb_ready),    32'(e.wb_ready));
      chk("mc_ready",    32'(mc_ready),    32'(e.mc_ready));
      chk("rf_we",       32'(rf_we),       32'(e.rf_we));
      chk("rf_a3",       32'(rf_a3),       32'(e.rf_a3));
      chk("rf_wd",       rf_wd,            e.rf_wd);
      chk("issue_ready", 32'(issue_ready), 32'(e.issue_ready));
      chk("rs1_busy",    32'(rs1_busy),    32'(e.rs1_busy));
      chk("rs2_busy",    32'(rs2_busy),    32'(e.rs2_busy));
    end
  end

  task automatic drive(input logic rst, input logic wv, input logic [4:0] wrd, input logic [31:0] wd,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                       input logic iv, input logic [4:0] ird, input logic [4:0] c1, input logic [4:0] c2);
    exp_t e;
    logic prio, gw, gm, ir;
    @(posedge clk);
    #1;
    reset = rst; wb_valid = wv; wb_rd = wrd; wb_data = wd;
    mc_valid = mv; mc_rd = mrd; mc_data = md;
    issue_valid = iv; issue_rd = ird; chk_rs1 = c1; chk_rs2 = c2;

    prio = (streak >= MAX_WAIT);
    gm   = !rst && mv && (prio || !wv);
    gw   = !rst && wv && !gm;
    ir   = !rst && !mbusy[ird];
    e.wb_ready    = gw;
    e.mc_ready    = gm;
    e.rf_we       = (gw && wrd != 0) || (gm && mrd != 0);
    e.rf_a3       = gw ? wrd : (gm ? mrd : 5'd0);
    e.rf_wd       = gw ? wd  : (gm ? md  : 32'd0);
    e.issue_ready = ir;
    e.rs1_busy    = mbusy[c1];
    e.rs2_busy    = mbusy[c2];
    exp_q.push_back(e);

    if (rst) begin
      streak = 0;
      mbusy  = '0;
    end else begin
      streak = (gm || !mv) ? 0 : streak + 1;
      if (gm) mbusy[mrd] = 1'b0;
      if (iv && ir && ird != 0) mbusy[ird] = 1'b1;
    end
    last_gw = gw;
    last_gm = gm;
  endtask

  initial begin
    logic        wb_pend, mc_pend, rst_r, iv_r;
    logic [4:0]  wrd_r, mrd_r, ird_r, c1_r, c2_r;
    logic [31:0] wd_r, md_r;

    reset = 1'b1; wb_valid = 0; mc_valid = 0; issue_valid = 0;
    wb_rd = 0; mc_rd = 0; issue_rd = 0; chk_rs1 = 0; chk_rs2 = 0;
    wb_data = 0; mc_data = 0;

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    drive(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);

    // Continuous WB traffic starving MC; MC must win on the fifth cycle.
    for (int i = 0; i < 5; i++)
      drive(0, 1, 12, 32'h1200 + 32'(i), 1, 7, 32'h77, 0, 0, 0, 0);
    drive(0, 1, 12, 32'h1299, 0, 0, 0, 0, 0, 0, 0);

    drive(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
    drive(0, 0, 0, 0, 1, 9, 32'h99, 0, 0, 9, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 9);

    drive(0, 1, 0, 32'h5555, 0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

    drive(0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0);
    drive(0, 0, 0, 0, 1, 4, 32'h44, 1, 3, 3, 4);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 4);
    drive(0, 0, 0, 0, 1, 3, 32'h33, 0, 0, 3, 4);

    // Escalate to MC priority with busy bits set, then reset mid-request.
    drive(0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 6, 5, 6);
    for (int i = 0; i < MAX_WAIT; i++)
      drive(0, 1, 2, 32'h2222, 1, 5, 32'h5050, 0, 0, 5, 6);
    drive(1, 1, 2, 32'h2222, 1, 5, 32'h5050, 1, 8, 5, 6);
    drive(0, 1, 2, 32'h2222, 1, 5, 32'h5050, 0, 0, 5, 6);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    wb_pend = 0; mc_pend = 0;
    wrd_r = 0; wd_r = 0; mrd_r = 0; md_r = 0;
    for (int n = 0; n < 800; n++) begin
      if (!wb_pend && $urandom_range(0, 3) != 0) begin
        wb_pend = 1;
        wrd_r   = 5'($urandom_range(0, 31));
        wd_r    = $urandom;
      end
      if (!mc_pend && $urandom_range(0, 2) == 0) begin
        mc_pend = 1;
        mrd_r   = 5'($urandom_range(0, 15));
        for (int t = 0; t < 32 && mbusy != 0 && !mbusy[mrd_r]; t++)
          mrd_r = 5'($urandom_range(0, 31));
        md_r    = $urandom;
      end
      rst_r = ($urandom_range(0, 79) == 0);
      iv_r  = ($urandom_range(0, 2) == 0);
      ird_r = 5'($urandom_range(0, 15));
      c1_r  = 5'($urandom_range(0, 15));
      c2_r  = 5'($urandom_range(0, 15));
      drive(rst_r, wb_pend, wrd_r, wd_r, mc_pend, mrd_r, md_r, iv_r, ird_r, c1_r, c2_r);
      if (last_gw) wb_pend = 0;
      if (last_gm) mc_pend = 0;
    end

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
